// File: rtl/iob_bus_arbiter_pkg.sv
// Shared definitions for the IOb N-to-1 bus arbiter: packed field layout, widths, state encoding.
package iob_bus_arbiter_pkg;

    // Arbiter state: a grant is either open (Busy) or not (Idle).
    typedef enum logic {
        Idle = 1'b0,
        Busy = 1'b1
    } arb_state_e;

    // Request slice {valid, address, wdata, wstrb}.
    function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response slice {rdata, ready}.
    function automatic int unsigned resp_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit positions inside one request slice.
    function automatic int unsigned req_valid_bit(input int unsigned addr_w,
                                                  input int unsigned data_w);
        return req_w(addr_w, data_w) - 1;
    endfunction

    function automatic int unsigned req_addr_lsb(input int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int unsigned req_wdata_lsb(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Bit positions inside one response slice.
    localparam int unsigned RespReadyBit = 0;
    localparam int unsigned RespRdataLsb = 1;

endpackage

// File: rtl/iob_bus_arbiter_if.sv
// IOb bus bundle between N requesting masters, the arbiter and the shared slave.
interface iob_bus_arbiter_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) ();

    localparam int unsigned REQ_W  = iob_bus_arbiter_pkg::req_w(ADDR_W, DATA_W);
    localparam int unsigned RESP_W = iob_bus_arbiter_pkg::resp_w(DATA_W);

    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;

    // Environment side: drives master requests and the slave response.
    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req
    );

    // Arbiter side: a slave to the requesting masters, forwarding to the shared slave.
    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req
    );

endinterface

// File: rtl/iob_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo N.
module iob_rr_pick
    import iob_bus_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Scan from farthest to nearest offset so the closest set request wins last.
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                winner = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/iob_bus_arbiter.sv
// N-master to 1-slave IOb arbiter: round-robin, registered grant held for a whole transaction,
// optional watchdog that force-completes a transaction the slave never answers.
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    iob_bus_arbiter_if.slave               bus,
    output logic [idx_w(N_MASTERS)-1:0]    gnt,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int unsigned REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int unsigned RESP_W = resp_w(DATA_W);
    localparam int unsigned IDX_W  = idx_w(N_MASTERS);
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REQ_W-1:0]     req_arr [N_MASTERS];
    logic [N_MASTERS-1:0] m_valid;
    logic [IDX_W-1:0]     pick;
    logic                 any_req;
    logic                 s_ready;
    logic                 wd_fire;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign req_arr[i] = bus.m_req[i*REQ_W +: REQ_W];
        assign m_valid[i] = req_arr[i][req_valid_bit(ADDR_W, DATA_W)];
    end

    assign s_ready = bus.s_resp[RespReadyBit];

    iob_rr_pick #(
        .N (N_MASTERS)
    ) u_pick (
        .req     (m_valid),
        .ptr     (rr_ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    // Watchdog fires in the TIMEOUT-th busy cycle unless the slave answers in that same cycle.
    if (TIMEOUT > 0) begin : g_wd
        assign wd_fire = (state_q == Busy) && !s_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_wd
        assign wd_fire = 1'b0;
    end

    // Next-state: grant on any request in Idle; release on slave ready or watchdog.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            Idle: begin
                if (any_req) begin
                    state_d = Busy;
                    gnt_d   = pick;
                    cnt_d   = '0;
                end
            end
            Busy: begin
                if (s_ready || wd_fire) begin
                    state_d  = Idle;
                    rr_ptr_d = (gnt_q == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_q + IDX_W'(1);
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Bus routing: only the granted master is connected; a watchdog completion is synthesised.
    always_comb begin
        bus.s_req   = '0;
        bus.m_resp  = '0;
        timeout_err = 1'b0;
        if (state_q == Busy) begin
            bus.s_req = req_arr[gnt_q];
            if (wd_fire) begin
                bus.s_req[req_valid_bit(ADDR_W, DATA_W)] = 1'b0;
                timeout_err = 1'b1;
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                if (IDX_W'(i) == gnt_q) begin
                    bus.m_resp[i*RESP_W +: RESP_W] = wd_fire ? RESP_W'(1) : bus.s_resp;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= Idle;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == Busy);

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Scoreboard bench for iob_bus_arbiter: a transaction-level model predicts grants and responses,
// a negedge monitor compares them with what the DUT presents.
module tb_iob_bus_arbiter;
    import iob_bus_arbiter_pkg::*;

    localparam int unsigned N      = 3;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned TO     = 8;
    localparam int unsigned REQ_W  = req_w(AW, DW);
    localparam int unsigned RESP_W = resp_w(DW);
    localparam int unsigned IW     = idx_w(N);
    localparam int          NEVER  = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] gnt;
    logic          busy;
    logic          timeout_err;

    iob_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    iob_bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .gnt         (gnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int m; logic [REQ_W-1:0] req; } g_exp_t;
    typedef struct { int cyc; logic [N*RESP_W-1:0] resp; bit te; } r_exp_t;

    g_exp_t exp_g[$];
    r_exp_t exp_r[$];
    int     obs_gnt[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     te_seen = 0;

    // Transaction-level model state.
    bit             pv [N];
    logic [AW-1:0]  pa [N];
    logic [DW-1:0]  pd [N];
    logic [SW-1:0]  ps [N];
    bit             mbusy = 0;
    int             mgnt = 0, ptr = 0, bc = 0, lat = 0;
    int             lat_fixed = -1;
    bit             force_rd = 0;
    logic [DW-1:0]  force_rd_val = '0;
    bit             stray_now = 0, stray_rand = 0;
    logic           s_rdy_drv = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*RESP_W-1:0] resp_vec(input int m, input logic [DW-1:0] d);
        logic [N*RESP_W-1:0] v;
        v = '0;
        v[m*RESP_W +: RESP_W] = {d, 1'b1};
        return v;
    endfunction

    function automatic logic [N-1:0] ready_bits();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = bus.m_resp[i*RESP_W];
        return r;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(15));
        if (r == 0) return NEVER;
        if (r == 1) return TO - 1;
        if (r == 2) return TO - 2;
        return 1 + int'($urandom_range(2));
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (pv[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_masters();
        for (int i = 0; i < N; i++) bus.m_req[i*REQ_W +: REQ_W] = {pv[i], pa[i], pd[i], ps[i]};
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        pv[i] = 1'b1; pa[i] = a; pd[i] = d; ps[i] = s;
    endtask

    task automatic issue_rand(input int i);
        issue(i, $urandom, $urandom, SW'($urandom));
    endtask

    // One clock: apply inputs, advance the model across the edge, then play the slave.
    task automatic step();
        int w;
        logic [DW-1:0] rd;
        drive_masters();
        @(posedge clk); #1;
        if (!mbusy) begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && pv[(ptr + k) % N]) w = (ptr + k) % N;
            if (w >= 0) begin
                mbusy = 1; mgnt = w; bc = 0;
                lat = (lat_fixed >= 0) ? lat_fixed : rand_lat();
                exp_g.push_back('{cyc, w, {1'b1, pa[w], pd[w], ps[w]}});
            end
        end else if (s_rdy_drv || bc == TO - 1) begin
            mbusy = 0; ptr = (mgnt + 1) % N; pv[mgnt] = 0;
        end else begin
            bc++;
        end
        rd = $urandom;
        if (mbusy) begin
            s_rdy_drv = (bc == lat);
            if (s_rdy_drv && force_rd) begin rd = force_rd_val; force_rd = 0; end
            if (s_rdy_drv) exp_r.push_back('{cyc, resp_vec(mgnt, rd), 1'b0});
            else if (bc == TO - 1) exp_r.push_back('{cyc, resp_vec(mgnt, '0), 1'b1});
        end else begin
            s_rdy_drv = stray_now || (stray_rand && $urandom_range(7) == 0);
        end
        stray_now = 0;
        bus.s_resp = {rd, s_rdy_drv};
    endtask

    task automatic model_clear();
        mbusy = 0; ptr = 0; bc = 0;
        for (int i = 0; i < N; i++) pv[i] = 0;
        exp_g.delete(); exp_r.delete();
        s_rdy_drv = 1'b0;
        bus.s_resp = '0;
        drive_masters();
    endtask

    task automatic do_reset();
        #2; rst = 1'b0;
        model_clear();
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && (mbusy || any_pending()); k++) step();
        repeat (3) step();
        chk({name, "_grant_q_empty"}, exp_g.size(), 0);
        chk({name, "_resp_q_empty"}, exp_r.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT opens a grant or presents a response.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        g_exp_t ge;
        r_exp_t re;
        if (!rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                if (exp_g.size() == 0) chk("grant_unexpected_busy", busy, 0);
                else begin
                    ge = exp_g.pop_front();
                    chk("grant_cycle", cyc, ge.cyc);
                    chk("grant_idx", gnt, ge.m);
                    chk("grant_s_req", bus.s_req, ge.req);
                    obs_gnt.push_back(int'(gnt));
                end
            end
            if (ready_bits() != '0 || timeout_err) begin
                if (timeout_err) te_seen++;
                if (exp_r.size() == 0) chk("resp_unexpected", {bus.m_resp, timeout_err}, 0);
                else begin
                    re = exp_r.pop_front();
                    chk("resp_cycle", cyc, re.cyc);
                    chk("resp_vec", bus.m_resp, re.resp);
                    chk("resp_timeout_err", timeout_err, re.te);
                    if (re.te) chk("timeout_s_valid", bus.s_req[REQ_W-1], 0);
                end
            end
            if (!busy) begin
                chk("idle_s_req_zero", bus.s_req, 0);
                chk("idle_m_resp_zero", bus.m_resp, 0);
            end
            busy_prev = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int te0;
        // Reset state with busy-looking inputs applied.
        for (int i = 0; i < N; i++) issue_rand(i);
        drive_masters();
        bus.s_resp = {32'hDEADBEEF, 1'b1};
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_gnt", gnt, 0);
        chk("reset_timeout_err", timeout_err, 0);
        chk("reset_s_req", bus.s_req, 0);
        chk("reset_m_resp", bus.m_resp, 0);
        model_clear();
        @(negedge clk); rst = 1'b1;

        // Single read by m0 with a 1-cycle slave.
        lat_fixed = 1; force_rd = 1; force_rd_val = 32'hCAFEF00D;
        issue(0, 32'h00001000, '0, '0);
        step(); step();
        chk("single_busy_hold", busy, 1);
        step();
        chk("single_busy_fall", busy, 0);
        drain("single");
        lat_fixed = -1;

        // Simultaneous requests after reset: m0 then m1.
        do_reset();
        obs_gnt.delete();
        issue_rand(0); issue_rand(1);
        drain("simul");
        chk("simul_count", obs_gnt.size(), 2);
        if (obs_gnt.size() == 2) begin
            chk("simul_first", obs_gnt[0], 0);
            chk("simul_second", obs_gnt[1], 1);
        end

        // Continuous contention between m0 and m1.
        do_reset();
        obs_gnt.delete();
        lat_fixed = 1;
        for (int k = 0; k < 200 && obs_gnt.size() < 10; k++) begin
            for (int i = 0; i < 2; i++) if (!pv[i]) issue_rand(i);
            step();
        end
        drain("contention");
        chk("contention_count_ok", obs_gnt.size() >= 10, 1);
        if (obs_gnt.size() >= 10) begin
            int zeros;
            zeros = 0;
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("contention_alt_%0d", k), obs_gnt[k], k % 2);
                if (obs_gnt[k] == 0) zeros++;
            end
            chk("contention_m0_share", zeros, 5);
        end

        // Write routing from m1.
        lat_fixed = 2;
        issue(1, 32'h0000_2040, 32'hA5A5A5A5, 4'b0011);
        drain("write");

        // Watchdog, stray late ready, then a normal grant.
        lat_fixed = NEVER;
        te0 = te_seen;
        issue_rand(0);
        step();
        for (int k = 0; k < 20 && mbusy; k++) step();
        step();
        stray_now = 1;
        step();
        step();
        chk("wd_single_pulse", te_seen - te0, 1);
        lat_fixed = 1;
        obs_gnt.delete();
        issue_rand(1);
        drain("wd_after");
        chk("wd_next_grant", (obs_gnt.size() == 1) ? obs_gnt[0] : -1, 1);

        // Asynchronous reset in the middle of a transaction.
        lat_fixed = NEVER;
        issue_rand(0);
        step(); step();
        chk("arst_pre_busy", busy, 1);
        #3; rst = 1'b0; #1;
        chk("arst_busy", busy, 0);
        chk("arst_s_valid", bus.s_req[REQ_W-1], 0);
        chk("arst_m_ready", ready_bits(), 0);
        model_clear();
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        lat_fixed = 1;
        issue_rand(1);
        drain("arst_after");

        // Randomized traffic with withdrawals, stray replies and mixed slave latency.
        lat_fixed = -1;
        stray_rand = 1;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(9) < 3) issue_rand(i);
                end else if (!(mbusy && mgnt == i) && $urandom_range(11) == 0) begin
                    pv[i] = 0;
                end
            end
            step();
        end
        stray_rand = 0;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_bus_arbiter.md
Name: iob_bus_arbiter

Overview:
- N-master to 1-slave arbiter on the IOb native bus.
- It shares one memory-side port, such as the external-memory (AXI bridge) port, between the CPU instruction bus, the CPU data bus and future bus masters (e.g. a DMA engine).
- Arbitration is round-robin with a registered grant. The grant is held for the whole transaction. An optional watchdog recovers from a slave that never answers.
- It sits between the bus splits and the memory controller and is instantiated where two split outputs target the same memory.

Parameters:
- N_MASTERS, 2, number of requesters (2..8); master 0 is the lowest index.
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Derived: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8 and RESP_W = DATA_W+1.
- TIMEOUT, 0, number of BUSY cycles without s_ready before forced completion. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- m_req  in  N_MASTERS*REQ_W  packed master requests {valid, address, wdata, wstrb}; master i occupies slice i.
- m_resp  out  N_MASTERS*RESP_W  packed master responses {rdata, ready}; slice i is for master i.
- s_req  out  REQ_W  request to the shared slave.
- s_resp  in  RESP_W  response from the shared slave.
- gnt  out  clog2(N_MASTERS) (min 1)  index of the current/last granted master (debug).
- busy  out  1  high while a transaction is in flight.
- timeout_err  out  1  one-cycle pulse on a watchdog-forced completion.

Behaviour:
- Protocol assumptions:
  - A master holds valid and all fields stable until it sees ready.
  - The slave pulses ready for exactly one cycle.
  - A master drops valid in the cycle after ready, or issues a new request.
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, rr_ptr=0, gnt=0, busy=0, timeout_err=0, watchdog counter=0.
  - s_req = all zeros; every m_resp ready=0 and rdata=0.
  - Reset mid-transaction abandons it silently; the slave is expected to be reset by the same signal.
- State IDLE:
  - s_valid=0 and all m_ready=0.
  - If any m_valid is set, the winner is the first set valid searched from rr_ptr upward, with wrap-around modulo N_MASTERS.
  - On a winner: gnt<=winner, busy<=1, state<=BUSY, counter<=0.
  - s_ready seen in IDLE (a late reply after a timeout) is ignored and is not forwarded.
- State BUSY:
  - s_req is driven combinationally from master gnt's slice.
  - s_resp is routed combinationally to master gnt only; other masters see ready=0 and rdata=0.
  - On s_ready=1: state<=IDLE, busy<=0, rr_ptr<=(gnt+1) mod N_MASTERS.
  - If TIMEOUT>0, the counter increments every BUSY cycle without s_ready. When counter==TIMEOUT-1 and s_ready=0:
    - the arbiter drives ready=1 and rdata=0 to master gnt and s_valid=0;
    - timeout_err=1 for that cycle;
    - the same state/rr_ptr update as a normal completion applies.
  - If s_ready and the timeout condition occur in the same cycle, the normal completion wins and timeout_err=0.
- Latency:
  - A request seen in IDLE at cycle t reaches the slave at t+1.
  - ready returns to the master combinationally in the slave's ready cycle r.
  - The next grant is decided at r+1, so the next slave access is at r+2 at the earliest. Peak throughput is one access per 2 cycles plus slave latency.
- Fairness:
  - A master that keeps requesting is served at least once every N_MASTERS transactions.
  - There is no starvation and no fixed priority; ties are resolved purely by rr_ptr.
- A master that withdraws valid before being granted is simply skipped; this is not a protocol error.
- The grant never changes while BUSY, even if the granted master misbehaves and drops valid. In that case s_valid follows the master's valid and the watchdog provides recovery.

Decomposition:
- Shared package/header:
  - REQ_W/RESP_W width macros.
  - Field slice macros (valid, address, wdata, wstrb, rdata, ready per index), reused from the existing IOb interconnect header.
  - State encoding constants IDLE=1'b0 and BUSY=1'b1.
- One sub-module: iob_rr_pick.
  - Combinational rotate-and-priority-encode.
  - Inputs: request vector and rr_ptr.
  - Outputs: winner index and an any_req flag.
  - Reusable by the peripheral-side and future DMA arbiters.

Test Plan (N_MASTERS=2, DATA_W=32, slave model with 1-cycle latency unless noted):
- Single request: m0 reads 0x00001000 in cycle 0 -> s_valid=1 with address 0x00001000 in cycle 1; slave returns 0xCAFEF00D with ready in cycle 2 -> m0 gets ready and 0xCAFEF00D in cycle 2; m1 ready stays 0; busy falls in cycle 3.
- Simultaneous requests after reset: m0 and m1 both valid in cycle 0 -> m0 is served first (rr_ptr=0) and m1 next, with gnt sequence 0,1; m1 is never starved.
- Continuous contention: both masters request back-to-back 10 times -> grants strictly alternate 0,1,0,1…; each master gets 5 completions of the first 10.
- Write routing: m1 writes 0xA5A5A5A5 with wstrb=4'b0011 while m0 is idle -> s_req carries m1's wdata and wstrb unmodified; m0 response is all zeros throughout.
- Watchdog: TIMEOUT=8, slave never asserts ready -> in the 8th BUSY cycle m_ready=1, rdata=0 and timeout_err=1 for one cycle; a stray s_ready 3 cycles later in IDLE is ignored; the next request is granted normally.
- Async reset mid-transaction: rst driven low while BUSY, between clock edges -> busy, s_valid and all m_ready drop immediately; after release, rr_ptr=0 and a new m1 request is served in 1+latency cycles.
